// File: rtl/spoofer_pkg.sv
// Shared definitions for the spoofer source and the spoofer Avalon-ST sink.
package spoofer_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_STEP       = 1;
   localparam logic [15:0] DEFAULT_LFSR_SEED  = 16'hACE1;

   // Saturation ceiling for the sink's mismatch counter.
   localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

   localparam int unsigned SINK_STATE_COUNT = 3;
   localparam int unsigned SINK_STATE_W     = $clog2(SINK_STATE_COUNT);

   typedef enum logic [SINK_STATE_W-1:0] {
      IDLE,
      LOCK,
      CHECK
   } sink_state_t;

endpackage

// File: rtl/spoofer_sink_avst_if.sv
// Avalon-ST beat channel (valid/data/ready) between a spoofer source and a sink.
interface spoofer_sink_avst_if
   import spoofer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/spoofer_sink_avst_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the sink's throttle source.
// load has priority over advance and restores SEED.
module lfsr16
   import spoofer_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        load,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic        feedback;

   // Next LFSR value: reload, shift, or hold.
   always_comb begin
      feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d   = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (advance) begin
         lfsr_d = {lfsr_q[14:0], feedback};
      end
   end

   // LFSR register, seeded on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/spoofer_sink_avst.sv
// Avalon-ST sink terminating the spoofer stream: locks onto the incrementing
// data sequence, counts accepted beats and sequence mismatches.
// Optional pseudo-random backpressure: define SPOOFER_SINK_THROTTLE_EN.
module spoofer_sink_avst
   import spoofer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned STEP       = DEFAULT_STEP,
   parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   spoofer_sink_avst_if.slave    st,
   output logic                  locked,
   output logic [31:0]           beat_count,
   output logic [15:0]           err_count,
   output logic                  err_sticky,
   output logic [DATA_WIDTH-1:0] last_data
);

   localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

   // A zero seed would lock the throttle LFSR in the all-zero state.
   if (LFSR_SEED == 16'h0000) begin : g_seed_check
      $error("spoofer_sink_avst: LFSR_SEED must be nonzero");
   end

   sink_state_t           state_q;
   sink_state_t           state_d;
   logic [DATA_WIDTH-1:0] expected_q;
   logic [DATA_WIDTH-1:0] expected_d;
   logic [31:0]           beat_count_q;
   logic [31:0]           beat_count_d;
   logic [15:0]           err_count_q;
   logic [15:0]           err_count_d;
   logic                  err_sticky_q;
   logic                  err_sticky_d;
   logic [DATA_WIDTH-1:0] last_data_q;
   logic [DATA_WIDTH-1:0] last_data_d;
   logic                  throttle_ok;
   logic                  xfer;

`ifdef SPOOFER_SINK_THROTTLE_EN
   logic [15:0] lfsr_q;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (state_q != IDLE),
      .load    (clear),
      .q       (lfsr_q)
   );

   assign throttle_ok = (lfsr_q[1:0] != 2'b00);
`else
   assign throttle_ok = 1'b1;
`endif

   // ready is built only from registers and enable/clear, never from valid/data.
   assign xfer = st.valid && st.ready;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: clear and enable-low both return to IDLE.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (enable) state_d = LOCK;
            LOCK: begin
               if (!enable)   state_d = IDLE;
               else if (xfer) state_d = CHECK;
            end
            CHECK:   if (!enable) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: handshake ready and lock indication.
   always_comb begin
      st.ready = enable && !clear && (state_q != IDLE) && throttle_ok;
      locked   = (state_q == CHECK);
   end

   // Datapath next values: clear wins, otherwise update only on a transfer.
   always_comb begin
      expected_d   = expected_q;
      beat_count_d = beat_count_q;
      err_count_d  = err_count_q;
      err_sticky_d = err_sticky_q;
      last_data_d  = last_data_q;
      if (clear) begin
         expected_d   = '0;
         beat_count_d = '0;
         err_count_d  = '0;
         err_sticky_d = 1'b0;
      end else if (xfer) begin
         beat_count_d = beat_count_q + 32'd1;
         last_data_d  = st.data;
         if (state_q == CHECK && st.data == expected_q) begin
            expected_d = expected_q + STEP_V;
         end else begin
            // Lock beat and mismatches both resync onto the received data.
            expected_d = st.data + STEP_V;
            if (state_q == CHECK) begin
               err_sticky_d = 1'b1;
               if (err_count_q != ERR_COUNT_MAX) begin
                  err_count_d = err_count_q + 16'd1;
               end
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expected_q   <= '0;
         beat_count_q <= '0;
         err_count_q  <= '0;
         err_sticky_q <= 1'b0;
         last_data_q  <= '0;
      end else begin
         expected_q   <= expected_d;
         beat_count_q <= beat_count_d;
         err_count_q  <= err_count_d;
         err_sticky_q <= err_sticky_d;
         last_data_q  <= last_data_d;
      end
   end

   assign beat_count = beat_count_q;
   assign err_count  = err_count_q;
   assign err_sticky = err_sticky_q;
   assign last_data  = last_data_q;

endmodule

// File: tb/tb_spoofer_sink_avst.sv
// Directed testbench for spoofer_sink_avst (throttle section compiled only
// with SPOOFER_SINK_THROTTLE_EN).
module tb_spoofer_sink_avst;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        clear;
   logic        locked;
   logic [31:0] beat_count;
   logic [15:0] err_count;
   logic        err_sticky;
   logic [31:0] last_data;

   int unsigned n_cmp;
   int unsigned n_fail;

   spoofer_sink_avst_if #(.DATA_WIDTH(32)) st_if ();

   spoofer_sink_avst #(
      .DATA_WIDTH (32),
      .STEP       (1),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (clear),
      .st         (st_if),
      .locked     (locked),
      .beat_count (beat_count),
      .err_count  (err_count),
      .err_sticky (err_sticky),
      .last_data  (last_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat, let one edge take it, return #1 after that edge.
   task automatic send(input logic [31:0] d);
      st_if.valid = 1'b1;
      st_if.data  = d;
      @(posedge clk);
      #1;
      st_if.valid = 1'b0;
   endtask

`ifdef SPOOFER_SINK_THROTTLE_EN
   bit pat_a[$];
   bit pat_b[$];

   task automatic run_throttled(input int unsigned which, output int unsigned beats);
      int unsigned cycles;
      logic        r;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(posedge clk); #1;
      beats  = 0;
      cycles = 0;
      while (beats < 1000 && cycles < 5000) begin
         st_if.valid = 1'b1;
         st_if.data  = beats;
         #1;
         r = st_if.ready;
         if (which == 0) pat_a.push_back(r);
         else            pat_b.push_back(r);
         @(posedge clk); #1;
         cycles++;
         if (r) beats++;
      end
      st_if.valid = 1'b0;
   endtask
`endif

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      enable      = 1'b0;
      clear       = 1'b0;
      st_if.valid = 1'b0;
      st_if.data  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",      st_if.ready, 0);
      check("rst_locked",     locked,      0);
      check("rst_beat_count", beat_count,  0);
      check("rst_err_count",  err_count,   0);
      check("rst_err_sticky", err_sticky,  0);
      check("rst_last_data",  last_data,   0);

      // Enable: ready stays low while IDLE, rises after IDLE->LOCK
      rst    = 1'b0;
      enable = 1'b1;
      #1;
      check("idle_ready_low", st_if.ready, 0);
      @(posedge clk); #1;
      check("lock_ready_high", st_if.ready, 1);
      check("lock_not_locked", locked,      0);

      // Back-to-back 0..99
      for (int unsigned i = 0; i < 100; i++) send(32'(i));
      check("seq100_beat_count", beat_count, 100);
      check("seq100_err_count",  err_count,  0);
      check("seq100_locked",     locked,     1);
      check("seq100_last_data",  last_data,  99);
      check("seq100_err_sticky", err_sticky, 0);

      // Clear with a valid beat pending: not transferred
      st_if.valid = 1'b1;
      st_if.data  = 32'd1234;
      clear       = 1'b1;
      #1;
      check("clear_ready_low", st_if.ready, 0);
      @(posedge clk); #1;
      clear       = 1'b0;
      st_if.valid = 1'b0;
      #1;
      check("clear_beat_count", beat_count,  0);
      check("clear_err_count",  err_count,   0);
      check("clear_err_sticky", err_sticky,  0);
      check("clear_locked",     locked,      0);
      check("clear_idle_ready", st_if.ready, 0);
      check("clear_last_kept",  last_data,   99);
      @(posedge clk); #1;

      // Relock with 5,6,7,20,21,9: mismatches on 20 and 9 only
      send(32'd5);
      check("relock_locked", locked, 1);
      check("relock_err",    err_count, 0);
      send(32'd6);
      send(32'd7);
      send(32'd20);
      check("mis20_err_count",  err_count,  1);
      check("mis20_err_sticky", err_sticky, 1);
      send(32'd21);
      check("resync21_err_count", err_count, 1);
      send(32'd9);
      check("mis9_err_count",  err_count,  2);
      check("mis9_beat_count", beat_count, 6);
      check("mis9_last_data",  last_data,  9);
      check("mis9_err_sticky", err_sticky, 1);

      // Wrap of the expected value
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(posedge clk); #1;
      send(32'hFFFF_FFFE);
      send(32'hFFFF_FFFF);
      send(32'h0000_0000);
      send(32'h0000_0001);
      check("wrap_err_count",  err_count,  0);
      check("wrap_beat_count", beat_count, 4);
      check("wrap_err_sticky", err_sticky, 0);
      check("wrap_last_data",  last_data,  1);

      // Enable gap: counters retained, relock without error
      enable = 1'b0;
      #1;
      check("dis_ready_low", st_if.ready, 0);
      @(posedge clk); #1;
      check("dis_unlocked",   locked,     0);
      check("dis_beat_kept",  beat_count, 4);
      enable = 1'b1;
      @(posedge clk); #1;
      send(32'd500);
      send(32'd501);
      check("reen_err_count",  err_count,  0);
      check("reen_beat_count", beat_count, 6);
      check("reen_locked",     locked,     1);

      // Asynchronous reset mid-stream
      st_if.valid = 1'b1;
      st_if.data  = 32'd502;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_ready",      st_if.ready, 0);
      check("arst_locked",     locked,      0);
      check("arst_beat_count", beat_count,  0);
      check("arst_err_count",  err_count,   0);
      check("arst_err_sticky", err_sticky,  0);
      check("arst_last_data",  last_data,   0);
      @(posedge clk); #1;
      rst         = 1'b0;
      st_if.valid = 1'b0;
      #1;
      check("post_rst_idle_ready", st_if.ready, 0);
      @(posedge clk); #1;
      check("post_rst_lock_ready", st_if.ready, 1);
      send(32'd7);
      send(32'd8);
      check("post_rst_beat_count", beat_count, 2);
      check("post_rst_err_count",  err_count,  0);
      check("post_rst_last_data",  last_data,  8);
      check("post_rst_locked",     locked,     1);

`ifdef SPOOFER_SINK_THROTTLE_EN
      begin
         int unsigned beats_a;
         int unsigned beats_b;
         int unsigned stalls;
         int unsigned diffs;
         run_throttled(0, beats_a);
         check("thr_a_beats",      beats_a,    1000);
         check("thr_a_beat_count", beat_count, 1000);
         check("thr_a_err_count",  err_count,  0);
         run_throttled(1, beats_b);
         check("thr_b_beat_count", beat_count, 1000);
         check("thr_b_err_count",  err_count,  0);
         stalls = 0;
         foreach (pat_a[i]) if (!pat_a[i]) stalls++;
         check("thr_has_stalls", (stalls > 0), 1);
         diffs = 0;
         foreach (pat_a[i]) if (i < pat_b.size() && pat_a[i] != pat_b[i]) diffs++;
         check("thr_pattern_len",  pat_b.size(), pat_a.size());
         check("thr_pattern_same", diffs,        0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spoofer_sink_avst.md
# spoofer_sink_avst

Avalon-ST sink that terminates the spoofer's streaming output in simulation and FPGA test builds. Drives `ready`, accepts beats, locks onto the spoofer's incrementing data sequence, and counts accepted beats and sequence mismatches. It provides the pass/fail observation point for spoofer-driven datapath tests, with optional pseudo-random backpressure to exercise the source's stall handling.

## Interface
- `DATA_WIDTH`, 32: width of `data` and of the expected-value register.
- `STEP`, 1: expected increment between consecutive beats, applied modulo 2^DATA_WIDTH.
- `LFSR_SEED`, 16'hACE1: throttle LFSR reset value; must be nonzero.

- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  sink active; when low, `ready` is 0.
- `clear`  in  1  synchronous clear of counters, sticky error, and FSM.
- `valid`  in  1  AVST source beat valid.
- `data`  in  DATA_WIDTH  AVST source beat data.
- `ready`  out  1  AVST sink ready.
- `locked`  out  1  FSM is in CHECK.
- `beat_count`  out  32  accepted beats; wraps.
- `err_count`  out  16  mismatched beats; saturates at 16'hFFFF.
- `err_sticky`  out  1  set on the first mismatch; cleared only by `rst` or `clear`.
- `last_data`  out  DATA_WIDTH  data of the most recent accepted beat.

## Operation
- A transfer occurs at a rising edge where `valid && ready`. No beat is consumed otherwise.
- `ready = enable && !clear && (state != IDLE) && throttle_ok`. It depends only on registers and `enable`/`clear`, never on `valid` or `data`.
- FSM states:
  - IDLE: ready low. Goes to LOCK on `enable`.
  - LOCK: first accepted beat sets `expected = data + STEP` and moves to CHECK. This beat is counted in `beat_count` and is never an error.
  - CHECK: each transfer compares `data` with `expected`.
    - Match: `expected += STEP`.
    - Mismatch: `err_count` +1 (saturating), `err_sticky` set, and `expected = data + STEP` (resync).
- `enable` low in LOCK or CHECK: next state is IDLE. Counters, `err_sticky`, and `last_data` are retained. Re-enabling relocks, with no error across the gap.
- `clear` high: next state is IDLE, `beat_count`, `err_count`, and `err_sticky` go to 0, `expected` goes to 0, and `last_data` is retained. Because `ready` is low that cycle, a simultaneous valid beat is not transferred.
- Wrap: `expected` and `data + STEP` are computed modulo 2^DATA_WIDTH. For example, 32'hFFFFFFFF followed by 32'h0 with STEP=1 is a match. `beat_count` wraps from 32'hFFFFFFFF to 0.
- Reset values: `ready`=0, `locked`=0, `beat_count`=0, `err_count`=0, `err_sticky`=0, `last_data`=0, `expected`=0, state IDLE, LFSR=`LFSR_SEED`.
- Reset asserted mid-stream forces everything to the reset values immediately. Any in-flight beat is dropped.

## Timing
- All counter, `err_sticky`, `last_data`, and `locked` updates take effect at the transfer edge and are visible in the following cycle.
- `ready` rises in the first cycle after the edge that moves the FSM from IDLE to LOCK, provided `throttle_ok` holds.
- The maximum rate is one beat per cycle with throttling compiled out.
- A mismatch at edge N shows `err_count` incremented in cycle N+1. The next in-sequence beat at edge N+1 is a match against the resynced expected value.

## Configuration
- `SPOOFER_SINK_THROTTLE_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle while the state is not IDLE.
  - `throttle_ok = (lfsr[1:0] != 2'b00)`, giving about 25% backpressure cycles in a repeatable sequence from `LFSR_SEED`.
  - `clear` reloads the LFSR with `LFSR_SEED`.
- Not defined: `throttle_ok` is tied to 1, the LFSR is not instantiated, and `LFSR_SEED` is unused.

## Structure
- Shared package `spoofer_pkg`:
  - `sink_state_t` enum (IDLE, LOCK, CHECK), with width from `$clog2` of the state count.
  - Default `DATA_WIDTH` and `STEP` constants, also used by the spoofer source.
  - `ERR_COUNT_MAX`.
- Sub-module `lfsr16` (seed parameter; ports `clk`, `rst`, `advance`, `load`, `q[15:0]`) holds the throttle generator. It is instantiated only under `SPOOFER_SINK_THROTTLE_EN`.

## Test plan
- Reset, then `enable`=1 with a source sending 0,1,2…99 back to back, throttle off: `ready` is high from the cycle after IDLE→LOCK. After the last beat, `beat_count`=100, `err_count`=0, `locked`=1, `last_data`=99.
- Sequence 5,6,7,20,21,9: exactly two mismatches (20 and 9), so `err_count`=2 and `err_sticky`=1. The beat 21 is a match after resync.
- STEP=1 stream 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1: `err_count`=0, `beat_count`=4.
- `clear` pulsed with `valid` high mid-stream: `ready`=0 that cycle and the beat is not transferred. The cycle after, counters are 0 and state is IDLE. The next beat relocks without error.
- `rst` asserted between clock edges mid-stream: all outputs read reset values before the next edge. After `rst` deasserts, operation resumes from IDLE.
- With `SPOOFER_SINK_THROTTLE_EN`, 1000 beats: `ready` is low on a nonzero fraction of cycles, the stall pattern is identical across two runs with the same seed, and the run ends with `beat_count`=1000 and `err_count`=0.
